// File: rtl/sqr_pkg.sv
// Shared definitions for the square-root requester: FSM state encoding,
// default operand width and default WAIT timeout.
package sqr_pkg;

   localparam int SQR_WIDTH_DEF   = 8;
   localparam int SQR_TIMEOUT_DEF = 64;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_OUT   = 3'd3,
      ST_ERR   = 3'd4
   } sqr_state_t;

   // Counter width able to hold the values 0 .. timeout-1.
   function automatic int timer_bits(input int timeout);
      if (timeout <= 2) begin
         return 1;
      end else begin
         return $clog2(timeout);
      end
   endfunction

endpackage

// File: rtl/sqr_timer.sv
// WAIT-cycle counter. Cleared by clr, advanced by en, and saturating at
// TIMEOUT-1, where expired is raised.
module sqr_timer
   import sqr_pkg::*;
#(
   parameter int TIMEOUT = SQR_TIMEOUT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = timer_bits(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] count_r;

   // Count WAIT cycles; the count holds once it has reached the last value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= '0;
      end else if (clr) begin
         count_r <= '0;
      end else if (en && (count_r != LAST)) begin
         count_r <= count_r + CW'(1);
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == LAST);

endmodule

// File: rtl/sqr_requester.sv
// Requester in front of a square-root control unit. It accepts one operand,
// pulses start, waits for core_done under a timeout, and then holds the result
// until the downstream side takes it. Only one job is in flight at a time.
module sqr_requester
   import sqr_pkg::*;
#(
   parameter int WIDTH   = SQR_WIDTH_DEF,
   parameter int TIMEOUT = SQR_TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             start,
   output logic [WIDTH-1:0] op_data,
   input  logic             core_done,
   input  logic [WIDTH-1:0] core_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             err,
   input  logic             err_clr,
   output logic [15:0]      job_count
);

   sqr_state_t       state_r;
   logic             start_r;
   logic             out_valid_r;
   logic             err_r;
   logic [WIDTH-1:0] op_data_r;
   logic [WIDTH-1:0] out_data_r;
   logic [15:0]      job_count_r;

   logic             timer_clr_s;
   logic             timer_en_s;
   logic             timer_expired_s;

   // Timer control: cleared while issuing start, advanced on every WAIT cycle
   // without a completion.
   always_comb begin
      timer_clr_s = 1'b0;
      timer_en_s  = 1'b0;
      if (state_r == ST_START) begin
         timer_clr_s = 1'b1;
      end else if ((state_r == ST_WAIT) && !core_done) begin
         timer_en_s = 1'b1;
      end else begin
         timer_clr_s = 1'b0;
         timer_en_s  = 1'b0;
      end
   end

   sqr_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .rst_n   (clear),
      .clr     (timer_clr_s),
      .en      (timer_en_s),
      .expired (timer_expired_s)
   );

   // Job FSM together with its registered outputs and data captures.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state_r     <= ST_IDLE;
         start_r     <= 1'b0;
         out_valid_r <= 1'b0;
         err_r       <= 1'b0;
         op_data_r   <= '0;
         out_data_r  <= '0;
         job_count_r <= 16'd0;
      end else begin
         start_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  op_data_r <= in_data;
                  start_r   <= 1'b1;
                  state_r   <= ST_START;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_START: begin
               // A core_done seen here belongs to no job of ours and is dropped.
               state_r <= ST_WAIT;
            end
            ST_WAIT: begin
               // Completion wins over a timeout reached in the same cycle.
               if (core_done) begin
                  out_data_r  <= core_result;
                  out_valid_r <= 1'b1;
                  state_r     <= ST_OUT;
               end else if (timer_expired_s) begin
                  err_r   <= 1'b1;
                  state_r <= ST_ERR;
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  job_count_r <= job_count_r + 16'd1;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r <= ST_OUT;
               end
            end
            ST_ERR: begin
               if (err_clr) begin
                  err_r   <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_ERR;
               end
            end
            default: begin
               out_valid_r <= 1'b0;
               err_r       <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = (state_r == ST_IDLE);
   assign start     = start_r;
   assign op_data   = op_data_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign err       = err_r;
   assign job_count = job_count_r;

endmodule

// File: tb/tb_sqr_requester.sv
// Self-checking bench for sqr_requester (WIDTH=8, TIMEOUT=4). A cycle-by-cycle
// vector table covers the main jobs; hand-written sequences cover the stall
// and the reset-in-WAIT corner cases.
module tb_sqr_requester;

   logic        clk;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        start;
   logic [7:0]  op_data;
   logic        core_done;
   logic [7:0]  core_result;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        err;
   logic        err_clr;
   logic [15:0] job_count;

   int total;
   int bad;

   typedef struct {
      logic        iv;
      logic [7:0]  id;
      logic        cd;
      logic [7:0]  cr;
      logic        ordy;
      logic        eclr;
      logic        e_ir;
      logic        e_st;
      logic        e_ov;
      logic [7:0]  e_od;
      logic        e_err;
      logic [15:0] e_jc;
      logic [7:0]  e_op;
   } vec_t;

   vec_t vecs[$];

   sqr_requester #(
      .WIDTH   (8),
      .TIMEOUT (4)
   ) dut (
      .clk         (clk),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .start       (start),
      .op_data     (op_data),
      .core_done   (core_done),
      .core_result (core_result),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .err         (err),
      .err_clr     (err_clr),
      .job_count   (job_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [7:0] id, input logic cd,
                        input logic [7:0] cr, input logic ordy, input logic eclr);
      in_valid    = iv;
      in_data     = id;
      core_done   = cd;
      core_result = cr;
      out_ready   = ordy;
      err_clr     = eclr;
   endtask

   task automatic add(input logic iv, input logic [7:0] id, input logic cd,
                      input logic [7:0] cr, input logic ordy, input logic eclr,
                      input logic e_ir, input logic e_st, input logic e_ov,
                      input logic [7:0] e_od, input logic e_err,
                      input logic [15:0] e_jc, input logic [7:0] e_op);
      vec_t v;
      v.iv = iv; v.id = id; v.cd = cd; v.cr = cr; v.ordy = ordy; v.eclr = eclr;
      v.e_ir = e_ir; v.e_st = e_st; v.e_ov = e_ov; v.e_od = e_od;
      v.e_err = e_err; v.e_jc = e_jc; v.e_op = e_op;
      vecs.push_back(v);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      clear = 1'b0;
      drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);

      // Columns: iv id cd cr ordy eclr | in_ready start out_valid out_data err job_count op_data
      // Basic job: operand 49, done in the 3rd WAIT cycle with result 7.
      add(1'b1, 8'd49, 1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 8'd0,  1'b0, 16'd0, 8'd49);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 16'd0, 8'd49);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 16'd0, 8'd49);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd0,  1'b0, 16'd0, 8'd49);
      add(1'b0, 8'd0,  1'b1, 8'd7,  1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 8'd7,  1'b0, 16'd0, 8'd49);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 8'd7,  1'b0, 16'd1, 8'd49);
      // core_done in IDLE is ignored.
      add(1'b0, 8'd0,  1'b1, 8'd99, 1'b0, 1'b0,  1'b1, 1'b0, 1'b0, 8'd7,  1'b0, 16'd1, 8'd49);
      // core_done in START is ignored; the WAIT one is taken.
      add(1'b1, 8'd25, 1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 8'd7,  1'b0, 16'd1, 8'd25);
      add(1'b0, 8'd0,  1'b1, 8'd99, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd7,  1'b0, 16'd1, 8'd25);
      add(1'b0, 8'd0,  1'b1, 8'd5,  1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 8'd5,  1'b0, 16'd1, 8'd25);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 8'd5,  1'b0, 16'd2, 8'd25);
      // Timeout: 4 WAIT cycles without done -> ERR; out_ready/core_done ignored there.
      add(1'b1, 8'd16, 1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 8'd5,  1'b0, 16'd2, 8'd16);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd5,  1'b0, 16'd2, 8'd16);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd5,  1'b0, 16'd2, 8'd16);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd5,  1'b0, 16'd2, 8'd16);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd5,  1'b0, 16'd2, 8'd16);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd5,  1'b1, 16'd2, 8'd16);
      add(1'b1, 8'd3,  1'b1, 8'd77, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 8'd5,  1'b1, 16'd2, 8'd16);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b1,  1'b1, 1'b0, 1'b0, 8'd5,  1'b0, 16'd2, 8'd16);
      // Boundary: done in the same cycle the timer reaches TIMEOUT-1.
      add(1'b1, 8'd100,1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b1, 1'b0, 8'd5,  1'b0, 16'd2, 8'd100);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd5,  1'b0, 16'd2, 8'd100);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd5,  1'b0, 16'd2, 8'd100);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd5,  1'b0, 16'd2, 8'd100);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b0, 1'b0,  1'b0, 1'b0, 1'b0, 8'd5,  1'b0, 16'd2, 8'd100);
      add(1'b0, 8'd0,  1'b1, 8'd10, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1, 8'd10, 1'b0, 16'd2, 8'd100);
      add(1'b0, 8'd0,  1'b0, 8'd0,  1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 8'd10, 1'b0, 16'd3, 8'd100);
      // Back-to-back: in_valid, core_done and out_ready held high; 4-cycle spacing.
      add(1'b1, 8'd144,1'b1, 8'd0,  1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 8'd10, 1'b0, 16'd3, 8'd144);
      add(1'b1, 8'd1,  1'b1, 8'd99, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 8'd10, 1'b0, 16'd3, 8'd144);
      add(1'b1, 8'd2,  1'b1, 8'd12, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 8'd12, 1'b0, 16'd3, 8'd144);
      add(1'b1, 8'd3,  1'b1, 8'd0,  1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 8'd12, 1'b0, 16'd4, 8'd144);
      add(1'b1, 8'd81, 1'b1, 8'd0,  1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 8'd12, 1'b0, 16'd4, 8'd81);
      add(1'b1, 8'd4,  1'b1, 8'd98, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 8'd12, 1'b0, 16'd4, 8'd81);
      add(1'b1, 8'd5,  1'b1, 8'd9,  1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 8'd9,  1'b0, 16'd4, 8'd81);
      add(1'b1, 8'd6,  1'b1, 8'd0,  1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 8'd9,  1'b0, 16'd5, 8'd81);
      add(1'b1, 8'd225,1'b1, 8'd0,  1'b1, 1'b0,  1'b0, 1'b1, 1'b0, 8'd9,  1'b0, 16'd5, 8'd225);
      add(1'b1, 8'd7,  1'b1, 8'd97, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0, 8'd9,  1'b0, 16'd5, 8'd225);
      add(1'b1, 8'd8,  1'b1, 8'd15, 1'b1, 1'b0,  1'b0, 1'b0, 1'b1, 8'd15, 1'b0, 16'd5, 8'd225);
      add(1'b0, 8'd9,  1'b0, 8'd0,  1'b1, 1'b0,  1'b1, 1'b0, 1'b0, 8'd15, 1'b0, 16'd6, 8'd225);

      // Reset state, checked while clear is held low.
      tick();
      tick();
      chk("rst in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst start",     {31'd0, start},     32'd0);
      chk("rst out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst err",       {31'd0, err},       32'd0);
      chk("rst op_data",   {24'd0, op_data},   32'd0);
      chk("rst out_data",  {24'd0, out_data},  32'd0);
      chk("rst job_count", {16'd0, job_count}, 32'd0);
      clear = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].iv, vecs[i].id, vecs[i].cd, vecs[i].cr, vecs[i].ordy, vecs[i].eclr);
         tick();
         chk($sformatf("v%0d in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
         chk($sformatf("v%0d start", i),     {31'd0, start},     {31'd0, vecs[i].e_st});
         chk($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
         chk($sformatf("v%0d out_data", i),  {24'd0, out_data},  {24'd0, vecs[i].e_od});
         chk($sformatf("v%0d err", i),       {31'd0, err},       {31'd0, vecs[i].e_err});
         chk($sformatf("v%0d job_count", i), {16'd0, job_count}, {16'd0, vecs[i].e_jc});
         chk($sformatf("v%0d op_data", i),   {24'd0, op_data},   {24'd0, vecs[i].e_op});
      end

      // Stall: result 8 held for 10 cycles with out_ready low, new operands ignored.
      drive(1'b1, 8'd64, 1'b0, 8'd0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 8'd0, 1'b1, 8'd8, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 8'(200 + k), 1'b1, 8'(50 + k), 1'b0, 1'b0);
         tick();
         chk($sformatf("stall%0d out_valid", k), {31'd0, out_valid}, 32'd1);
         chk($sformatf("stall%0d out_data", k),  {24'd0, out_data},  32'd8);
         chk($sformatf("stall%0d in_ready", k),  {31'd0, in_ready},  32'd0);
         chk($sformatf("stall%0d op_data", k),   {24'd0, op_data},   32'd64);
      end
      drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
      tick();
      chk("stall release out_valid", {31'd0, out_valid}, 32'd0);
      chk("stall release job_count", {16'd0, job_count}, 32'd7);
      chk("stall release in_ready",  {31'd0, in_ready},  32'd1);

      // Reset in WAIT: outputs clear at once, a late done is ignored.
      drive(1'b1, 8'd36, 1'b0, 8'd0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      tick();
      tick();
      #2;
      clear = 1'b0;
      #1;
      chk("wrst in_ready",  {31'd0, in_ready},  32'd1);
      chk("wrst op_data",   {24'd0, op_data},   32'd0);
      chk("wrst out_data",  {24'd0, out_data},  32'd0);
      chk("wrst job_count", {16'd0, job_count}, 32'd0);
      chk("wrst start",     {31'd0, start},     32'd0);
      tick();
      clear = 1'b1;
      drive(1'b0, 8'd0, 1'b1, 8'd6, 1'b1, 1'b0);
      tick();
      chk("wrst late done out_valid", {31'd0, out_valid}, 32'd0);
      chk("wrst late done in_ready",  {31'd0, in_ready},  32'd1);
      chk("wrst late done out_data",  {24'd0, out_data},  32'd0);
      drive(1'b1, 8'd36, 1'b0, 8'd0, 1'b0, 1'b0);
      tick();
      chk("wrst job start", {31'd0, start}, 32'd1);
      drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 8'd0, 1'b1, 8'd6, 1'b0, 1'b0);
      tick();
      chk("wrst job out_valid", {31'd0, out_valid}, 32'd1);
      chk("wrst job out_data",  {24'd0, out_data},  32'd6);
      drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
      tick();
      chk("wrst job job_count", {16'd0, job_count}, 32'd1);
      chk("wrst job in_ready",  {31'd0, in_ready},  32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
